// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: all four CPOL/CPHA modes, configurable word width and bit order,
// multi-word frames, first-word-fall-through RX FIFO and a valid/ready TX word source.
module spi_slave_param #(
    parameter int DATA_W     = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overflow,
    input  logic              ovf_clr,
    output logic              busy
);
    // Handshakes: a TX word is taken only at a load point (tx_ready pulses if tx_valid was high,
    // tx_underrun otherwise); an RX word leaves the FIFO on any cycle with rx_valid && rx_ready.
    localparam int CNT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;

    logic [1:0]        sclk_sync, ss_sync, mosi_sync;
    logic              sclk_d, ss_d;
    logic              cpol_q, cpha_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_next, tx_shifted, tx_word;
    logic              need_load, hold_first, push_req, frame_start;
    logic              ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic              lead_edge, trail_edge, sample_edge, shift_edge;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full, pop, wr_en;

    // Synchronisers reset low so a select held low across reset never looks like a new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            ss_sync   <= {ss_sync[0], ss_n};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_d    <= sclk_sync[1];
            ss_d      <= ss_sync[1];
        end
    end

    assign ss_fall     = ss_d & ~ss_sync[1];
    assign ss_rise     = ~ss_d & ss_sync[1];
    assign sclk_rise   = ~sclk_d & sclk_sync[1];
    assign sclk_fall   = sclk_d & ~sclk_sync[1];
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = busy & ~ss_rise & (cpha_q ? trail_edge : lead_edge);
    assign shift_edge  = busy & ~ss_rise & (cpha_q ? lead_edge : trail_edge);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d     = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q == ACTIVE);
    assign miso_oe    = busy;
    assign miso       = busy & (MSB_FIRST ? tx_sr[DATA_W-1] : tx_sr[0]);
    assign rx_next    = MSB_FIRST ? {rx_sr[DATA_W-2:0], mosi_sync[1]} : {mosi_sync[1], rx_sr[DATA_W-1:1]};
    assign tx_shifted = MSB_FIRST ? {tx_sr[DATA_W-2:0], 1'b0} : {1'b0, tx_sr[DATA_W-1:1]};
    assign tx_word    = tx_valid ? tx_data : '0;

    // In cpha=1 the first leading edge only presents the already-loaded bit, so it must not shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            need_load   <= 1'b0;
            hold_first  <= 1'b0;
            push_req    <= 1'b0;
            tx_ready    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            push_req    <= 1'b0;
            tx_ready    <= 1'b0;
            tx_underrun <= 1'b0;
            if (frame_start) begin
                cpol_q      <= cpol;
                cpha_q      <= cpha;
                bit_cnt     <= '0;
                need_load   <= 1'b0;
                hold_first  <= cpha;
                tx_sr       <= tx_word;
                tx_ready    <= tx_valid;
                tx_underrun <= ~tx_valid;
            end else begin
                if (sample_edge) begin
                    rx_sr <= rx_next;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt   <= '0;
                        need_load <= 1'b1;
                        push_req  <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                if (shift_edge) begin
                    if (need_load) begin
                        need_load   <= 1'b0;
                        tx_sr       <= tx_word;
                        tx_ready    <= tx_valid;
                        tx_underrun <= ~tx_valid;
                    end else if (hold_first) begin
                        hold_first <= 1'b0;
                    end else begin
                        tx_sr <= tx_shifted;
                    end
                end
            end
        end
    end

    // rx_sr still holds the completed word in the cycle after the final sample.
    assign fifo_full = (fifo_cnt == FULL_CNT);
    assign rx_valid  = (fifo_cnt != '0);
    assign pop       = rx_valid & rx_ready;
    assign wr_en     = push_req & (~fifo_full | pop);
    assign rx_data   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= rx_sr;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (ovf_clr)                           rx_overflow <= 1'b0;
            else if (push_req & fifo_full & ~pop)  rx_overflow <= 1'b1;
        end
    end
endmodule
